fft_peak_detect: RTL
====================

// Module: fft_peak_detect
// PURPOSE
//  Downstream consumer of the fft core's output stream. Sits on done/wd.
//  Computes |X[k]|^2 = re^2 + im^2 for each of the N = 2**N_2 output bins.
//  Reports the bin index and magnitude of the strongest bin once per frame,
//  plus a threshold-crossing flag. Used for tone detection after the FFT.
// PARAMETERS
//  WIDTH    16  bits per real/imag component (signed, two's complement)
//  N_2      5   log2(FFT length); N = 2**N_2 bins per frame
//  SKIP_DC  1   1: bin 0 excluded from the search; 0: all bins searched
// PORTS
//  clk        in   1          clock; all logic on posedge
//  reset      in   1          synchronous, active-low reset
//  in_valid   in   1          connect to fft done; high while bins stream
//  in_data    in   2*WIDTH    connect to fft wd; {re[2W-1:W], im[W-1:0]}
//  threshold  in   2*WIDTH    unsigned magnitude-squared threshold
//  peak_valid out  1          1-cycle pulse: peak_idx/peak_mag/above valid
//  peak_idx   out  N_2        index of largest bin in last frame
//  peak_mag   out  2*WIDTH    unsigned re^2+im^2 of that bin
//  above      out  1          peak_mag >= threshold, sampled with the frame
//  frame_err  out  1          1-cycle pulse: frame aborted (valid dropped early)
//  busy       out  1          high in ACCUM state
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, bin counter=0, pipeline valid=0.
//   Outputs 0: peak_valid, peak_idx, peak_mag, above, frame_err, busy.
//   Reset mid-frame discards the frame. No peak_valid or frame_err is emitted.
//  Input protocol: bin k is presented on the k-th consecutive cycle with in_valid=1.
//   Frame starts on the first in_valid=1 seen in IDLE (that beat is bin 0).
//   in_valid may stay high after bin N-1; the fft holds done.
//  FSM:
//   IDLE  : in_valid=1 -> accept bin 0, cnt=1, go ACCUM.
//   ACCUM : in_valid=1 -> accept bin cnt, cnt++. After bin N-1 -> go HOLD.
//           in_valid=0 with cnt<N -> pulse frame_err next cycle, flush, go IDLE.
//   HOLD  : ignore in_data. Wait for in_valid=0, then go IDLE.
//           The next frame needs >=1 low cycle first.
//  Arithmetic: signed re*re + im*im into 2*WIDTH unsigned bits.
//   Max is 2*(2^(W-1))^2 = 2^(2W-1); no overflow, no saturation.
//  Pipeline:
//   S1 registers mag, idx, first, last.
//   S2 compares against the running max. First searched bin loads the max unconditionally.
//   Replace only on strictly greater; ties keep the lower index.
//   SKIP_DC=1: bin 0 never enters the compare; bin 1 is the first searched.
//  Latency: bin N-1 is sampled at edge E. Outputs update at E+2.
//   At E+2, peak_valid=1 for exactly one cycle.
//   peak_idx/peak_mag/above hold until the next peak_valid or reset.
//  frame_err: asserted the cycle after in_valid falls in ACCUM.
//   In-flight S1 data is discarded. Running max is cleared.
//  threshold is sampled at the S2 edge that produces peak_valid.
// TESTING
//  1 Single tone: bin5={4000,0000}, other bins 0, SKIP_DC=1
//    -> peak_valid 2 cycles after bin31; idx=5, mag=32'h1000_0000.
//  2 All-zero frame -> idx=1 (SKIP_DC=1), mag=0, above=(threshold==0).
//  3 Tie: bins 3 and 7 = {0100,0100}, rest 0 -> idx=3, mag=32'h0002_0000.
//  4 Extreme: bin 9 = {8000,8000} -> mag=32'h8000_0000, no wrap.
//    threshold=32'h8000_0000 -> above=1.
//  5 Abort: in_valid high 10 cycles then low
//    -> frame_err pulses once, no peak_valid. Next full frame reports correctly.
//  6 Hold + reset: in_valid high 40 cycles -> exactly one peak_valid.
//    reset=0 at bin 20 of a later frame -> all outputs 0, no pulses.

Source files
------------

// File: rtl/fft_peak_detect.sv
// rtl/fft_peak_detect.sv - strongest-bin and threshold detector on the FFT output stream
// Frames of N=2**N_2 bins are squared, searched for the maximum, and reported two edges after the last bin.
module fft_peak_detect #(
  parameter int WIDTH   = 16,
  parameter int N_2     = 5,
  parameter int SKIP_DC = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [2*WIDTH-1:0]   in_data,
  input  logic [2*WIDTH-1:0]   threshold,
  output logic                 peak_valid,
  output logic [N_2-1:0]       peak_idx,
  output logic [2*WIDTH-1:0]   peak_mag,
  output logic                 above,
  output logic                 frame_err,
  output logic                 busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [N_2-1:0] LAST_IDX  = {N_2{1'b1}};
  localparam logic [N_2-1:0] FIRST_IDX = (SKIP_DC != 0) ? N_2'(1) : '0;

  logic [1:0]           state_q, state_d;
  logic [N_2-1:0]       cnt_q, cnt_d;
  logic                 accept, abort;
  logic [N_2-1:0]       acc_idx;

  logic                 cap_valid_q;
  logic [2*WIDTH-1:0]   cap_data_q;
  logic [N_2-1:0]       cap_idx_q;

  logic                 s1_valid_q, s1_first_q, s1_last_q;
  logic [2*WIDTH-1:0]   s1_mag_q;
  logic [N_2-1:0]       s1_idx_q;

  logic [2*WIDTH-1:0]   max_mag_q;
  logic [N_2-1:0]       max_idx_q;

  logic                 peak_valid_q, above_q, frame_err_q;
  logic [N_2-1:0]       peak_idx_q;
  logic [2*WIDTH-1:0]   peak_mag_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    abort   = 1'b0;
    acc_idx = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          acc_idx = '0;
          cnt_d   = N_2'(1);
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          accept = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = HOLD;
          end
        end else begin
          abort   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (!in_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sign-extend before squaring so the full-scale product (-2^(W-1))^2 stays exact.
  logic signed [2*WIDTH-1:0] re_ext, im_ext, re_sq, im_sq;
  logic [2*WIDTH-1:0]        mag_comb;

  assign re_ext   = {{WIDTH{cap_data_q[2*WIDTH-1]}}, cap_data_q[2*WIDTH-1:WIDTH]};
  assign im_ext   = {{WIDTH{cap_data_q[WIDTH-1]}}, cap_data_q[WIDTH-1:0]};
  assign re_sq    = re_ext * re_ext;
  assign im_sq    = im_ext * im_ext;
  assign mag_comb = $unsigned(re_sq) + $unsigned(im_sq);

  logic                 take_new;
  logic [2*WIDTH-1:0]   new_mag;
  logic [N_2-1:0]       new_idx;

  // Strictly greater replaces, so on a tie the earlier (lower) bin survives.
  assign take_new = s1_first_q || (s1_mag_q > max_mag_q);
  assign new_mag  = take_new ? s1_mag_q : max_mag_q;
  assign new_idx  = take_new ? s1_idx_q : max_idx_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cap_valid_q  <= 1'b0;
      cap_data_q   <= '0;
      cap_idx_q    <= '0;
      s1_valid_q   <= 1'b0;
      s1_first_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_mag_q     <= '0;
      s1_idx_q     <= '0;
      max_mag_q    <= '0;
      max_idx_q    <= '0;
      peak_valid_q <= 1'b0;
      peak_idx_q   <= '0;
      peak_mag_q   <= '0;
      above_q      <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cap_valid_q  <= accept && ((SKIP_DC == 0) || (acc_idx != '0));
      cap_data_q   <= in_data;
      cap_idx_q    <= acc_idx;
      s1_valid_q   <= cap_valid_q && !abort;
      s1_mag_q     <= mag_comb;
      s1_idx_q     <= cap_idx_q;
      s1_first_q   <= (cap_idx_q == FIRST_IDX);
      s1_last_q    <= (cap_idx_q == LAST_IDX);
      peak_valid_q <= 1'b0;
      frame_err_q  <= abort;
      if (abort) begin
        max_mag_q <= '0;
        max_idx_q <= '0;
      end else if (s1_valid_q) begin
        max_mag_q <= new_mag;
        max_idx_q <= new_idx;
        if (s1_last_q) begin
          peak_valid_q <= 1'b1;
          peak_idx_q   <= new_idx;
          peak_mag_q   <= new_mag;
          above_q      <= (new_mag >= threshold);
        end
      end
    end
  end

  assign peak_valid = peak_valid_q;
  assign peak_idx   = peak_idx_q;
  assign peak_mag   = peak_mag_q;
  assign above      = above_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q == ACCUM);

endmodule
